// File: rtl/dma_copy_engine.sv
// dma_copy_engine
//   Bus initiator that copies len_words 32-bit words from src_addr to
//   dst_addr over the CPU-style data memory request/stall interface.
//   Each word is one read access followed by one write access. An access
//   completes on the first cycle where a stall has been observed and
//   mem_clk_stall is low again; an access that runs TIMEOUT_CYCLES cycles
//   (counted from its request cycle) without completing aborts the copy.
//
//   Optional feature: define DMA_CHECKSUM_EN to add the checksum output,
//   a rotate-and-XOR accumulation of every word written.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   start               begin a copy (sampled only while idle)
//   src_addr, dst_addr  word-aligned byte addresses
//   len_words           number of words to copy
//   busy                high whenever not idle
//   done                one-cycle pulse at the end of every copy
//   err                 sticky error, cleared by the next accepted start
//   mem_addr            access address
//   mem_write_data      write data
//   mem_memwrite        write strobe
//   mem_memread         read strobe
//   mem_sign_mask       constant word-access encoding
//   mem_read_data       read data from memory
//   mem_clk_stall       memory busy indication
//   checksum            running checksum (DMA_CHECKSUM_EN only)
module dma_copy_engine #(
  parameter int         LEN_WIDTH      = 16,
  parameter int         TIMEOUT_CYCLES = 64,
  parameter logic [3:0] WORD_SIGN_MASK = 4'b0100
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [31:0]          src_addr,
  input  logic [31:0]          dst_addr,
  input  logic [LEN_WIDTH-1:0] len_words,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [31:0]          mem_addr,
  output logic [31:0]          mem_write_data,
  output logic                 mem_memwrite,
  output logic                 mem_memread,
  output logic [3:0]           mem_sign_mask,
  input  logic [31:0]          mem_read_data,
  input  logic                 mem_clk_stall
`ifdef DMA_CHECKSUM_EN
  ,
  output logic [31:0]          checksum
`endif
);

  localparam int TCNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR_REQ,
    WR_WAIT,
    FIN
  } state_t;

  state_t               state;
  logic [31:0]          src_ptr;
  logic [31:0]          dst_ptr;
  logic [LEN_WIDTH-1:0] remaining;
  logic [TCNT_W-1:0]    tcnt;
  logic                 seen_stall;
  logic                 acc_done;
  logic                 acc_timeout;

  assign mem_sign_mask = WORD_SIGN_MASK;

  // Completion can only happen in a WAIT state: the request cycle itself
  // cannot both record a stall and see it released. Completion on the
  // last allowed cycle wins over the timeout.
  always_comb begin
    acc_done    = 1'b0;
    acc_timeout = 1'b0;
    if (state == RD_REQ || state == RD_WAIT || state == WR_REQ || state == WR_WAIT) begin
      acc_done    = (state == RD_WAIT || state == WR_WAIT) && seen_stall && !mem_clk_stall;
      acc_timeout = !acc_done && (tcnt == TCNT_W'(TIMEOUT_CYCLES));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      src_ptr        <= '0;
      dst_ptr        <= '0;
      remaining      <= '0;
      tcnt           <= '0;
      seen_stall     <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err            <= 1'b0;
      mem_addr       <= '0;
      mem_write_data <= '0;
      mem_memwrite   <= 1'b0;
      mem_memread    <= 1'b0;
`ifdef DMA_CHECKSUM_EN
      checksum       <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            src_ptr   <= src_addr;
            dst_ptr   <= dst_addr;
            remaining <= len_words;
            err       <= 1'b0;
            busy      <= 1'b1;
`ifdef DMA_CHECKSUM_EN
            checksum  <= '0;
`endif
            if (src_addr[1:0] != 2'b00 || dst_addr[1:0] != 2'b00) begin
              err   <= 1'b1;
              done  <= 1'b1;
              state <= FIN;
            end else if (len_words == '0) begin
              done  <= 1'b1;
              state <= FIN;
            end else begin
              mem_memread <= 1'b1;
              mem_addr    <= src_addr;
              tcnt        <= TCNT_W'(1);
              state       <= RD_REQ;
            end
          end
        end

        RD_REQ, RD_WAIT, WR_REQ, WR_WAIT: begin
          if (acc_timeout) begin
            // Abandon the access and the rest of the run.
            mem_memread  <= 1'b0;
            mem_memwrite <= 1'b0;
            err          <= 1'b1;
            done         <= 1'b1;
            state        <= FIN;
          end else if (acc_done && state == RD_WAIT) begin
            // Read data goes straight into the write data register.
            mem_memread    <= 1'b0;
            mem_memwrite   <= 1'b1;
            mem_addr       <= dst_ptr;
            mem_write_data <= mem_read_data;
            tcnt           <= TCNT_W'(1);
            state          <= WR_REQ;
          end else if (acc_done) begin
            mem_memwrite <= 1'b0;
            src_ptr      <= src_ptr + 32'd4;
            dst_ptr      <= dst_ptr + 32'd4;
            remaining    <= remaining - LEN_WIDTH'(1);
`ifdef DMA_CHECKSUM_EN
            checksum     <= {checksum[30:0], checksum[31]} ^ mem_write_data;
`endif
            if (remaining == LEN_WIDTH'(1)) begin
              done  <= 1'b1;
              state <= FIN;
            end else begin
              mem_memread <= 1'b1;
              mem_addr    <= src_ptr + 32'd4;
              tcnt        <= TCNT_W'(1);
              state       <= RD_REQ;
            end
          end else begin
            tcnt <= tcnt + TCNT_W'(1);
            // The request cycle restarts stall tracking for this access.
            if (state == RD_REQ || state == WR_REQ) begin
              seen_stall <= mem_clk_stall;
            end else begin
              seen_stall <= seen_stall | mem_clk_stall;
            end
            if (state == RD_REQ) begin
              state <= RD_WAIT;
            end else if (state == WR_REQ) begin
              state <= WR_WAIT;
            end
          end
        end

        FIN: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
